// File: rtl/dma_halt_sequencer.sv
// dma_halt_sequencer
// Bus-ownership sequencer for the PhantomRAM DMA datapath. Halts the 6809,
// waits out the halt latency, and issues one DMA byte cycle per E clock.
// Long transfers are split into bursts so the CPU runs between them and can
// service interrupts. All outputs are registered.
// The FSM state is visible as state_q (typed enum) for debug and checkers.
//
// Build option: define NMI_ON_DONE_EN to drive nmi_drv from the completion
// flag. Without it, nmi_drv is tied low and irq_flag can only be polled.
//
// Handshake: start is a level, sampled only in IDLE. abort is taken in any
// state. done is a one-cycle pulse. irq_flag is sticky until irq_ack; if
// irq_ack and completion land in the same cycle, the flag stays set.
module dma_halt_sequencer #(
  parameter int LEN_W      = 16,
  parameter int HALT_WAIT  = 3,
  parameter int BURST_MAX  = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic             e_cpu,
  input  logic             _reset_cpu,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len_in,
  input  logic             irq_ack,
  output logic             halt_drv,
  output logic             dma_en,
  output logic             step,
  output logic [LEN_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             irq_flag,
  output logic             nmi_drv
);

  localparam int CNT_W   = 16;
  localparam int BURST_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALTING,
    S_XFER,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t             state_q, state_n;
  logic [LEN_W-1:0]   remaining_n;
  logic [CNT_W-1:0]   wait_q, wait_n;
  logic [BURST_W-1:0] burst_q, burst_n;
  logic               burst_hit;
  logic               irq_n;

  // The burst limit applies only when BURST_MAX is nonzero.
  always_comb begin
    burst_hit = 1'b0;
    if (BURST_MAX != 0) begin
      burst_hit = (burst_q == BURST_W'(BURST_MAX - 1));
    end
  end

  // Next-state logic. Counters and the sticky completion flag are updated here.
  always_comb begin
    state_n     = state_q;
    remaining_n = remaining;
    wait_n      = wait_q;
    burst_n     = burst_q;
    irq_n       = irq_flag;

    if (irq_ack) begin
      irq_n = 1'b0;
    end

    if (abort) begin
      state_n     = S_IDLE;
      remaining_n = '0;
      wait_n      = '0;
      burst_n     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_in != '0) begin
              remaining_n = len_in;
              wait_n      = CNT_W'(HALT_WAIT);
              state_n     = S_HALTING;
            end else begin
              remaining_n = '0;
              state_n     = S_DONE;
            end
          end
        end
        S_HALTING: begin
          if (wait_q <= CNT_W'(1)) begin
            wait_n  = '0;
            burst_n = '0;
            state_n = S_XFER;
          end else begin
            wait_n = wait_q - CNT_W'(1);
          end
        end
        S_XFER: begin
          // Saturating decrement keeps remaining from wrapping.
          remaining_n = (remaining != '0) ? remaining - LEN_W'(1) : '0;
          burst_n     = burst_q + BURST_W'(1);
          // The last byte goes straight to DONE, so no empty gap follows it.
          if (remaining <= LEN_W'(1)) begin
            state_n = S_DONE;
          end else if (burst_hit) begin
            wait_n  = CNT_W'(GAP_CYCLES);
            state_n = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (wait_q <= CNT_W'(1)) begin
            wait_n  = CNT_W'(HALT_WAIT);
            state_n = S_HALTING;
          end else begin
            wait_n = wait_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          irq_n   = 1'b1;
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State register. Outputs are registered from the decoded next state.
  always_ff @(posedge e_cpu) begin
    if (!_reset_cpu) begin
      state_q   <= S_IDLE;
      remaining <= '0;
      wait_q    <= '0;
      burst_q   <= '0;
      halt_drv  <= 1'b0;
      dma_en    <= 1'b0;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      irq_flag  <= 1'b0;
      nmi_drv   <= 1'b0;
    end else begin
      state_q   <= state_n;
      remaining <= remaining_n;
      wait_q    <= wait_n;
      burst_q   <= burst_n;
      halt_drv  <= (state_n == S_HALTING) || (state_n == S_XFER);
      dma_en    <= (state_n == S_XFER);
      step      <= (state_n == S_XFER);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      irq_flag  <= irq_n;
`ifdef NMI_ON_DONE_EN
      nmi_drv   <= irq_n;
`else
      nmi_drv   <= 1'b0;
`endif
    end
  end

endmodule
